// File: rtl/klein_key_gen_e.sv
// KLEIN-80 forward key schedule: loads an 80-bit master key and streams round keys 1..17.
// Optional final key export is enabled by defining KLEIN_KEYGEN_FINAL_KEY_EN.
module klein_key_gen_e (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [63:0] rk_data,
  output logic [4:0]  rk_round,
  output logic        rk_valid,
  input  logic        rk_ready
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
  ,
  output logic [79:0] final_key,
  output logic        final_valid
`endif
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [79:0] k_q, k_d;
  logic [4:0]  i_q, i_d;
  logic        load, xfer, last;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'hA;
      4'h3: y = 4'h9;
      4'h4: y = 4'h1;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h0;
      4'h8: y = 4'hC;
      4'h9: y = 4'h3;
      4'hA: y = 4'h2;
      4'hB: y = 4'h6;
      4'hC: y = 4'h8;
      4'hD: y = 4'hE;
      4'hE: y = 4'hD;
      default: y = 4'h5;
    endcase
    return y;
  endfunction

  // One schedule step: byte-rotate both halves, Feistel-like mix, round constant, S-boxes.
  function automatic logic [79:0] klein_update(input logic [79:0] k, input logic [4:0] rnd);
    logic [39:0] a_rot, b_rot, a_n, b_n;
    a_rot = {k[71:40], k[79:72]};
    b_rot = {k[31:0], k[39:32]};
    a_n = b_rot;
    a_n[23:16] = a_n[23:16] ^ {3'b000, rnd};
    b_n = a_rot ^ b_rot;
    b_n[31:28] = sbox(b_n[31:28]);
    b_n[27:24] = sbox(b_n[27:24]);
    b_n[23:20] = sbox(b_n[23:20]);
    b_n[19:16] = sbox(b_n[19:16]);
    return {a_n, b_n};
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (key_valid) state_d = StRun;
      StRun:   if (rk_ready && last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    key_ready = (state_q == StIdle);
    rk_valid  = (state_q == StRun);
  end

  assign rk_data  = k_q[79:16];
  assign rk_round = i_q;
  assign load     = key_ready && key_valid;
  assign xfer     = rk_valid && rk_ready;
  assign last     = (i_q == 5'd17);

  always_comb begin
    k_d = k_q;
    i_d = i_q;
    if (load) begin
      k_d = key_in;
      i_d = 5'd1;
    end else if (xfer && !last) begin
      k_d = klein_update(k_q, i_q);
      i_d = i_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      i_q <= '0;
    end else begin
      k_q <= k_d;
      i_q <= i_d;
    end
  end

`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
  logic [79:0] final_key_q, final_key_d;
  logic        final_valid_q, final_valid_d;

  // Captured on the last transfer: the starting key of the decryption-direction schedule.
  always_comb begin
    final_key_d   = final_key_q;
    final_valid_d = final_valid_q;
    if (load) begin
      final_valid_d = 1'b0;
    end else if (xfer && last) begin
      final_key_d   = k_q;
      final_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      final_key_q   <= '0;
      final_valid_q <= 1'b0;
    end else begin
      final_key_q   <= final_key_d;
      final_valid_q <= final_valid_d;
    end
  end

  assign final_key   = final_key_q;
  assign final_valid = final_valid_q;
`endif

endmodule

// File: tb/tb_klein_key_gen_e.sv
// Directed self-checking bench for klein_key_gen_e with a byte-oriented reference schedule.
// Final-key checks are compiled in when KLEIN_KEYGEN_FINAL_KEY_EN is defined.
module tb_klein_key_gen_e;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] rk_data;
  logic [4:0]  rk_round;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
  logic [79:0] final_key;
  logic        final_valid;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rk [1:17];
  logic [79:0] exp_fin;

  klein_key_gen_e dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .rk_data     (rk_data),
    .rk_round    (rk_round),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready)
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
    ,
    .final_key   (final_key),
    .final_valid (final_valid)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h74A91FB0C3268ED5;
    return t[63-4*x -: 4];
  endfunction

  // Reference step on byte arrays, index 0 = most significant byte of each 40-bit half.
  function automatic logic [79:0] model_next(input logic [79:0] k, input int rnd);
    logic [7:0] a [5];
    logic [7:0] b [5];
    logic [7:0] na [5];
    logic [7:0] nb [5];
    logic [79:0] r;
    for (int j = 0; j < 5; j++) begin
      a[j] = k[79-8*j -: 8];
      b[j] = k[39-8*j -: 8];
    end
    for (int j = 0; j < 5; j++) begin
      na[j] = b[(j+1)%5];
      nb[j] = a[(j+1)%5] ^ b[(j+1)%5];
    end
    na[2] = na[2] ^ 8'(rnd);
    nb[1] = {sb(nb[1][7:4]), sb(nb[1][3:0])};
    nb[2] = {sb(nb[2][7:4]), sb(nb[2][3:0])};
    for (int j = 0; j < 5; j++) begin
      r[79-8*j -: 8] = na[j];
      r[39-8*j -: 8] = nb[j];
    end
    return r;
  endfunction

  task automatic build_model(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int r = 1; r <= 17; r++) begin
      exp_rk[r] = k[79:16];
      if (r < 17) k = model_next(k, r);
    end
    exp_fin = k;
  endtask

  task automatic load_key(input logic [79:0] key);
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({key_ready, rk_valid, rk_data, rk_round} !== {1'b1, 1'b0, 64'h0, 5'd0}) begin
      errors++;
      $display("FAIL reset_outputs got kr=%b v=%b d=%h r=%0d want kr=1 v=0 d=0 r=0",
               key_ready, rk_valid, rk_data, rk_round);
    end
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
    checks++;
    if (final_valid !== 1'b0 || final_key !== 80'h0) begin
      errors++;
      $display("FAIL reset_final got v=%b k=%h want v=0 k=0", final_valid, final_key);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got kr=%b v=%b want kr=1 v=0", key_ready, rk_valid);
    end
  endtask

  task automatic test_zero_key;
    int cnt;
    build_model(80'h0);
    rk_ready = 1'b1;
    @(negedge clk);
    key_in    = '0;
    key_valid = 1'b1;
    cnt       = 0;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    cnt       = 1;
    checks++;
    if ({rk_valid, key_ready, rk_round, rk_data} !== {1'b1, 1'b0, 5'd1, 64'h0}) begin
      errors++;
      $display("FAIL zero_r1 got v=%b kr=%b r=%0d d=%h want v=1 kr=0 r=1 d=0",
               rk_valid, key_ready, rk_round, rk_data);
    end
    @(posedge clk);
    #1;
    cnt = 2;
    checks++;
    if (rk_round !== 5'd2 || rk_data !== 64'h0000010000007777) begin
      errors++;
      $display("FAIL zero_r2 got r=%0d d=%h want r=2 d=0000010000007777", rk_round, rk_data);
    end
    while (!key_ready && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checks++;
    if (cnt !== 18) begin
      errors++;
      $display("FAIL zero_key_ready_latency got %0d want 18", cnt);
    end
    checks++;
    if (rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_valid_drop got %b want 0", rk_valid);
    end
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
    checks++;
    if (final_valid !== 1'b1 || final_key !== exp_fin) begin
      errors++;
      $display("FAIL zero_final got v=%b k=%h want v=1 k=%h", final_valid, final_key, exp_fin);
    end
`endif
  endtask

  task automatic test_backpressure(input logic [79:0] key);
    build_model(key);
    rk_ready = 1'b1;
    load_key(key);
    for (int r = 1; r <= 2; r++) begin
      checks++;
      if (rk_round !== 5'(r) || rk_data !== exp_rk[r]) begin
        errors++;
        $display("FAIL bp_pre r=%0d got r=%0d d=%h want d=%h", r, rk_round, rk_data, exp_rk[r]);
      end
      @(posedge clk);
      #1;
    end
    rk_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 5'd3 || rk_data !== exp_rk[3]) begin
        errors++;
        $display("FAIL bp_hold got v=%b r=%0d d=%h want v=1 r=3 d=%h",
                 rk_valid, rk_round, rk_data, exp_rk[3]);
      end
    end
    rk_ready = 1'b1;
    for (int r = 3; r <= 17; r++) begin
      checks++;
      if (rk_round !== 5'(r) || rk_data !== exp_rk[r]) begin
        errors++;
        $display("FAIL bp_post r=%0d got r=%0d d=%h want d=%h", r, rk_round, rk_data, exp_rk[r]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end got kr=%b v=%b want kr=1 v=0", key_ready, rk_valid);
    end
  endtask

  task automatic test_model;
    logic [79:0] key;
    rk_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      key = 80'({$urandom, $urandom, $urandom});
      build_model(key);
      load_key(key);
      for (int r = 1; r <= 17; r++) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 5'(r) || rk_data !== exp_rk[r]) begin
          errors++;
          $display("FAIL model k%0d r=%0d got v=%b r=%0d d=%h want d=%h",
                   n, r, rk_valid, rk_round, rk_data, exp_rk[r]);
        end
        @(posedge clk);
        #1;
      end
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
      checks++;
      if (final_valid !== 1'b1 || final_key !== exp_fin) begin
        errors++;
        $display("FAIL model_final k%0d got %h want %h", n, final_key, exp_fin);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    logic [79:0] key_b;
    build_model(80'h0123456789ABCDEF0011);
    rk_ready = 1'b1;
    load_key(80'h0123456789ABCDEF0011);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (rk_round !== 5'd9 || rk_data !== exp_rk[9]) begin
      errors++;
      $display("FAIL mid_r9 got r=%0d d=%h want r=9 d=%h", rk_round, rk_data, exp_rk[9]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({key_ready, rk_valid, rk_data, rk_round} !== {1'b1, 1'b0, 64'h0, 5'd0}) begin
      errors++;
      $display("FAIL mid_reset got kr=%b v=%b d=%h r=%0d want kr=1 v=0 d=0 r=0",
               key_ready, rk_valid, rk_data, rk_round);
    end
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
    checks++;
    if (final_valid !== 1'b0 || final_key !== 80'h0) begin
      errors++;
      $display("FAIL mid_reset_final got v=%b k=%h want v=0 k=0", final_valid, final_key);
    end
`endif
    @(negedge clk);
    rst   = 1'b0;
    key_b = 80'hFEDCBA98765432100FF0;
    build_model(key_b);
    load_key(key_b);
    for (int r = 1; r <= 17; r++) begin
      checks++;
      if (rk_round !== 5'(r) || rk_data !== exp_rk[r]) begin
        errors++;
        $display("FAIL mid_restart r=%0d got r=%0d d=%h want d=%h",
                 r, rk_round, rk_data, exp_rk[r]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_during_run;
    build_model(80'hA5A5_5A5A_C3C3_3C3C_F00F);
    rk_ready = 1'b1;
    load_key(80'hA5A5_5A5A_C3C3_3C3C_F00F);
    for (int r = 1; r <= 17; r++) begin
      checks++;
      if (rk_round !== 5'(r) || rk_data !== exp_rk[r]) begin
        errors++;
        $display("FAIL run_load r=%0d got r=%0d d=%h want d=%h", r, rk_round, rk_data, exp_rk[r]);
      end
      key_valid = (r == 5);
      key_in    = 80'h1111_2222_3333_4444_5555;
      @(posedge clk);
      #1;
    end
    key_valid = 1'b0;
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_load_end key_ready got %b want 1", key_ready);
    end
`ifdef KLEIN_KEYGEN_FINAL_KEY_EN
    checks++;
    if (final_valid !== 1'b1 || final_key !== exp_fin) begin
      errors++;
      $display("FAIL final_hold got v=%b k=%h want v=1 k=%h", final_valid, final_key, exp_fin);
    end
    load_key(80'h0);
    checks++;
    if (final_valid !== 1'b0) begin
      errors++;
      $display("FAIL final_clear got %b want 0", final_valid);
    end
    repeat (17) @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_key();
    test_backpressure(80'h1357_9BDF_2468_ACE0_1122);
    test_model();
    test_reset_mid();
    test_load_during_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
